// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg: shared types and constants for the PS/2 receive path.
//   ps2_state_e   - deframer FSM states (idle, data bits, parity, stop)
//   PS2_DATA_BITS - payload bits per frame
//   PS2_BREAK     - break prefix scan code, also decoded by the keyboard controller
//   PS2_EXT       - extended prefix scan code, also decoded by the keyboard controller
package ps2_rx_pkg;

   localparam int unsigned PS2_DATA_BITS = 8;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: show-ahead scan-code FIFO.
//   clk, rst      - system clock, asynchronous active-high reset (empties the FIFO)
//   push_i        - request to write push_data_i
//   push_data_i   - scan code to store
//   pop_i         - consumer ready; an entry is removed only when the FIFO is non-empty
//   data_o        - head entry, 8'h00 while empty
//   valid_o       - FIFO non-empty
//   drop_o        - push refused because the FIFO was full and nothing was popped
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module ps2_rx_fifo
   import ps2_rx_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [PS2_DATA_BITS-1:0] push_data_i,
   input  logic                     pop_i,
   output logic [PS2_DATA_BITS-1:0] data_o,
   output logic                     valid_o,
   output logic                     drop_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]                wr_ptr_q, wr_ptr_d;
   logic [AW:0]                rd_ptr_q, rd_ptr_d;
   logic [PS2_DATA_BITS-1:0]   mem_q [DEPTH];

   logic empty, full, do_push, do_pop;

   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop  = pop_i & ~empty;
      do_push = push_i & (~full | do_pop);
      drop_o  = push_i & ~do_push;

      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

      valid_o = ~empty;
      data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: contents are only visible while non-empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver.
// Synchronises the raw PS/2 pins, deframes 11-bit frames (start, 8 data LSB first,
// odd parity, stop), and queues good scan codes in a show-ahead FIFO.
//   clk, rst      - system clock, asynchronous active-high reset
//   ps2_clk       - raw PS/2 clock pin (asynchronous)
//   ps2_data      - raw PS/2 data pin (asynchronous)
//   data_out      - FIFO head scan code, 8'h00 when empty
//   valid         - FIFO non-empty
//   ready         - consumer accepts data_out this cycle
//   frame_err     - one-cycle pulse on a rejected or abandoned frame
//   overflow      - sticky: a good byte was dropped because the FIFO was full
//   overflow_clr  - synchronous clear of overflow (a same-cycle set wins)
// Build option: define PS2_RX_TIMEOUT_EN to abandon partial frames after
// TIMEOUT_CYCLES clocks without a falling ps2_clk edge.
module ps2_rx_frame
   import ps2_rx_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] data_out,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overflow,
   input  logic       overflow_clr
);

   localparam int unsigned CntW = $clog2(PS2_DATA_BITS);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   // Synchroniser: reset to 1 (idle bus) so leaving reset never looks like a falling edge.
   logic clk_s1_q, clk_s2_q, clk_hist_q;
   logic data_s1_q, data_s2_q;
   logic fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_hist_q <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_hist_q <= clk_s2_q;
         data_s1_q  <= ps2_data;
         data_s2_q  <= data_s1_q;
      end
   end

   assign fall = clk_hist_q & ~clk_s2_q;

   // Deframer state
   ps2_state_e               state_q, state_d;
   logic [CntW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
   logic                     parity_q, parity_d;
   logic                     frame_err_q, frame_err_d;
   logic                     overflow_q, overflow_d;
   logic                     push;
   logic                     fifo_drop;
   logic                     timeout;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

   // Counts idle-bus cycles inside a frame; any falling edge restarts it.
   always_comb begin
      tmo_cnt_d = '0;
      timeout   = 1'b0;
      if (state_q != StIdle && !fall) begin
         if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      parity_d    = parity_q;
      frame_err_d = 1'b0;
      push        = 1'b0;

      if (timeout) begin
         state_d     = StIdle;
         frame_err_d = 1'b1;
      end else if (fall) begin
         unique case (state_q)
            StIdle: begin
               if (!data_s2_q) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            StData: begin
               shreg_d   = {data_s2_q, shreg_q[PS2_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + CntW'(1);
               if (bit_cnt_q == CntW'(PS2_DATA_BITS - 1)) begin
                  state_d = StParity;
               end
            end
            StParity: begin
               parity_d = data_s2_q;
               state_d  = StStop;
            end
            StStop: begin
               state_d = StIdle;
               // Good frame: stop bit high and odd parity across data + parity.
               if (data_s2_q && ((^shreg_q) ^ parity_q)) begin
                  push = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      if (fifo_drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         parity_q    <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         parity_q    <= parity_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (shreg_q),
      .pop_i       (ready),
      .data_o      (data_out),
      .valid_o     (valid),
      .drop_o      (fifo_drop)
   );

   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: randomized bench for ps2_rx_frame.
// A queue-based model of the scan-code FIFO is advanced once per clock and
// compared with the DUT outputs on every falling clock edge.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TMO   = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       ready = 1'b0;
   logic       overflow_clr = 1'b0;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ps2_rx_frame #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .data_out     (data_out),
      .valid        (valid),
      .ready        (ready),
      .frame_err    (frame_err),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   typedef enum int {EvNone, EvStop, EvGlitch, EvMark} ev_e;
   logic [7:0] q[$];
   bit         exp_ovf = 1'b0;
   int         exp_err = 0;
   int         seen_err = 0;
   int         cyc = 0;
   int         mark_cyc = 0;
   int         err_cyc = 0;
   bit         prev_err = 1'b0;
   bit         chk_en = 1'b0;
   bit         rand_ready = 1'b0;
   ev_e        ev_kind = EvNone;
   logic [7:0] ev_byte = 8'h00;
   bit         ev_good = 1'b0;

   // Model: the sender posts an event the cycle before the DUT acts on that edge.
   always @(posedge clk) begin
      bit set_ovf;
      cyc++;
      set_ovf = 1'b0;
      if (!rst) begin
         if (ready && q.size() > 0) void'(q.pop_front());
         case (ev_kind)
            EvStop: begin
               if (!ev_good) exp_err++;
               else if (q.size() < DEPTH) q.push_back(ev_byte);
               else set_ovf = 1'b1;
            end
            EvGlitch: exp_err++;
            EvMark:   mark_cyc = cyc;
            default: ;
         endcase
         if (set_ovf) exp_ovf = 1'b1;
         else if (overflow_clr) exp_ovf = 1'b0;
      end
      ev_kind = EvNone;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("valid", valid, q.size() > 0);
         check_eq("data_out", data_out, (q.size() > 0) ? q[0] : 8'h00);
         check_eq("overflow", overflow, exp_ovf);
         check_eq("err_width", frame_err & prev_err, 1'b0);
      end
      if (frame_err) begin
         seen_err++;
         err_cyc = cyc;
      end
      prev_err = frame_err;
      if (rand_ready) ready = ($urandom % 3) == 0;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: got no finish expected finish before 3ms");
      $fatal(1, "watchdog");
   end

   // One PS/2 bit: data set up, clock low, then high; events posted just before the DUT samples.
   task automatic ps2_bit(input logic b, input ev_e kind, input logic [7:0] byt, input bit good,
                          input bit pop_now);
      int half;
      half = $urandom_range(4, 9);
      @(negedge clk);
      ps2_data = b;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      ev_byte = byt;
      ev_good = good;
      ev_kind = kind;
      if (pop_now) ready = 1'b1;
      @(negedge clk);
      if (pop_now) ready = 1'b0;
      repeat (half - 2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (half) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit pop_on_stop);
      logic p, s;
      bit   good;
      p    = ~(^b) ^ bad_par;
      s    = ~bad_stop;
      good = (s == 1'b1) && (((^b) ^ p) == 1'b1);
      ps2_bit(1'b0, EvNone, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], EvNone, 8'h00, 1'b0, 1'b0);
      ps2_bit(p, EvNone, 8'h00, 1'b0, 1'b0);
      ps2_bit(s, EvStop, b, good, pop_on_stop);
   endtask

   // Start bit plus the first n data bits; the last falling edge is marked.
   task automatic send_partial(input logic [7:0] b, input int n);
      ps2_bit(1'b0, (n == 0) ? EvMark : EvNone, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) ps2_bit(b[i], (i == n - 1) ? EvMark : EvNone, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic drain();
      @(negedge clk);
      ready = 1'b1;
      repeat (DEPTH + 2) @(negedge clk);
      ready = 1'b0;
      @(negedge clk);
      check_eq("drained_valid", valid, 1'b0);
      check_eq("drained_data", data_out, 8'h00);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check_eq("rst_valid", valid, 1'b0);
      check_eq("rst_data", data_out, 8'h00);
      check_eq("rst_err", frame_err, 1'b0);
      check_eq("rst_ovf", overflow, 1'b0);

      // Good frame
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      check_eq("good_data", data_out, 8'h1C);
      check_eq("good_valid", valid, 1'b1);
      check_eq("good_noerr", seen_err, 0);
      drain();

      // Bad parity, then a good break code
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
      check_eq("badpar_err", seen_err, exp_err);
      check_eq("badpar_valid", valid, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      check_eq("break_data", data_out, 8'hF0);
      drain();

      // Bad stop bit and a stray idle-bus edge with data high
      send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
      ps2_bit(1'b1, EvGlitch, 8'h00, 1'b0, 1'b0);
      check_eq("glitch_err", seen_err, exp_err);

      // Overflow
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
      check_eq("ovf_set", overflow, 1'b1);
      check_eq("ovf_head", data_out, 8'h01);
      drain();
      @(negedge clk) overflow_clr = 1'b1;
      @(negedge clk) overflow_clr = 1'b0;
      check_eq("ovf_clr", overflow, 1'b0);

      // Full FIFO: pop in the same cycle as the stop-bit edge
      for (int i = 1; i <= 8; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      send_frame(8'h2A, 1'b0, 1'b0, 1'b1);
      check_eq("fullpp_ovf", overflow, 1'b0);
      check_eq("fullpp_head", data_out, 8'h12);
      drain();

`ifdef PS2_RX_TIMEOUT_EN
      send_partial(8'h55, 5);
      repeat (TMO + 20) @(negedge clk);
      exp_err++;
      check_eq("tmo_err", seen_err, exp_err);
      check_eq("tmo_latency", err_cyc - mark_cyc, TMO);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      check_eq("tmo_next", data_out, 8'hF0);
`else
      // Without the timeout the receiver waits indefinitely for the rest of the frame.
      send_partial(8'h55, 5);
      repeat (200) @(negedge clk);
      check_eq("wait_noerr", seen_err, exp_err);
      for (int i = 5; i < 8; i++) ps2_bit(1'b0 ^ ((8'h55 >> i) & 1), EvNone, 8'h00, 1'b0, 1'b0);
      ps2_bit(~(^8'h55), EvNone, 8'h00, 1'b0, 1'b0);
      ps2_bit(1'b1, EvStop, 8'h55, 1'b1, 1'b0);
      check_eq("wait_data", data_out, 8'h55);
`endif
      drain();

      // Reset mid-frame with bytes queued
      send_frame(8'hA1, 1'b0, 1'b0, 1'b0);
      send_frame(8'hB2, 1'b0, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
      send_partial(8'h33, 3);
      ps2_clk = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      q.delete();
      exp_ovf = 1'b0;
      #1;
      check_eq("midrst_valid", valid, 1'b0);
      check_eq("midrst_data", data_out, 8'h00);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      check_eq("postrst_data", data_out, 8'h1C);
      drain();

      // Random frames with random consumer back-pressure
      rand_ready = 1'b1;
      for (int n = 0; n < 24; n++) begin
         int r;
         r = $urandom % 10;
         if (r == 0) ps2_bit(1'b1, EvGlitch, 8'h00, 1'b0, 1'b0);
         else send_frame(8'($urandom), r == 1, r == 2, 1'b0);
      end
      rand_ready = 1'b0;
      drain();
      check_eq("rand_err", seen_err, exp_err);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
